// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle processor.
// Steps each instruction through fetch, decode, execute, memory and writeback,
// and drives the datapath selects plus the ungated RegW/MemW/Branch requests.
// Every output except Illegal comes from the state register alone.
module multicycle_main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  // The register is a plain vector so the six unused codes (10..15) are
  // representable; they decode to all-zero outputs and fall back to FETCH.
  logic [3:0] state_reg;
  state_t     state_next;

  // Only the I and L/S bits of Funct steer this machine.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state selection; Op/Funct are only consulted in DECODE and MEMADR.
  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;   // illegal opcode retires as a NOP
        endcase
      end
      MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWR:    state_next = FETCH;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  // Moore output decode; Illegal is the single Mealy term (DECODE with Op=11).
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    Illegal   = 1'b0;
    case (state_reg)
      FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        // PC+8 is formed here so R15 reads see the architectural value.
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        Illegal   = (Op == 2'b11);
      end
      MEMADR: begin
        ALUSrcB   = 2'b01;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
      end
      EXECUTER: begin
        ALUOp     = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB   = 2'b01;
        ALUOp     = 1'b1;
      end
      ALUWB: begin
        RegW      = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: directed vector table,
// hand-written reset/unencoded-state sequences, and randomized instructions
// checked against an instruction-level phase model.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .Illegal   (Illegal)
  );

  // Observed outputs packed as
  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal}
  logic [14:0] obs;
  assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                ALUOp, NextPC, RegW, MemW, Branch, Illegal};

  // Output signatures of each phase, written straight from the state table.
  localparam logic [14:0] O_FETCH  = 15'b1_0_01_10_10_0_1_0_0_0_0;
  localparam logic [14:0] O_DECODE = 15'b0_0_01_10_10_0_0_0_0_0_0;
  localparam logic [14:0] O_DECILL = 15'b0_0_01_10_10_0_0_0_0_0_1;
  localparam logic [14:0] O_MEMADR = 15'b0_0_00_01_00_0_0_0_0_0_0;
  localparam logic [14:0] O_MEMRD  = 15'b0_1_00_00_00_0_0_0_0_0_0;
  localparam logic [14:0] O_MEMWB  = 15'b0_0_00_00_01_0_0_1_0_0_0;
  localparam logic [14:0] O_MEMWR  = 15'b0_1_00_00_00_0_0_0_1_0_0;
  localparam logic [14:0] O_EXR    = 15'b0_0_00_00_00_1_0_0_0_0_0;
  localparam logic [14:0] O_EXI    = 15'b0_0_00_01_00_1_0_0_0_0_0;
  localparam logic [14:0] O_ALUWB  = 15'b0_0_00_00_00_0_0_1_0_0_0;
  localparam logic [14:0] O_BRANCH = 15'b0_0_00_01_10_0_0_0_0_1_0;
  localparam logic [14:0] O_ZERO   = 15'b0;

  typedef struct packed {
    logic [1:0]       op;
    logic [5:0]       funct;
    logic [2:0]       len;
    logic [4:0][14:0] exp;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] funct,
                              input logic [2:0] len,
                              input logic [14:0] e0, input logic [14:0] e1,
                              input logic [14:0] e2, input logic [14:0] e3,
                              input logic [14:0] e4);
    vec_t v;
    v.op = op; v.funct = funct; v.len = len;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    return v;
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  // Precondition: at a falling edge with the DUT in FETCH.
  task automatic run_vec(input vec_t v, input string tag);
    Op = v.op;
    Funct = v.funct;
    for (int k = 0; k < int'(v.len); k++) begin
      check($sformatf("%s cyc%0d", tag, k), obs, v.exp[k]);
      @(posedge clk);
      @(negedge clk);
    end
    $display("vector %s op=%b funct=%b len=%0d done", tag, v.op, v.funct, v.len);
  endtask

  // Phase model: what an instruction does, step by step, as plain rules.
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4,
                 P_MW = 5, P_ER = 6, P_EI = 7, P_AW = 8, P_BR = 9;

  function automatic logic [14:0] phase_out(input int p, input logic [1:0] op);
    case (p)
      P_F:     return O_FETCH;
      P_D:     return (op == 2'b11) ? O_DECILL : O_DECODE;
      P_MA:    return O_MEMADR;
      P_MR:    return O_MEMRD;
      P_MWB:   return O_MEMWB;
      P_MW:    return O_MEMWR;
      P_ER:    return O_EXR;
      P_EI:    return O_EXI;
      P_AW:    return O_ALUWB;
      P_BR:    return O_BRANCH;
      default: return O_ZERO;
    endcase
  endfunction

  task automatic model_phases(input logic [1:0] op, input logic [5:0] funct, output int q[$]);
    q = {};
    q.push_back(P_F);
    q.push_back(P_D);
    case (op)
      2'b00: begin
        q.push_back(funct[5] ? P_EI : P_ER);
        q.push_back(P_AW);
      end
      2'b01: begin
        q.push_back(P_MA);
        if (funct[0]) begin
          q.push_back(P_MR);
          q.push_back(P_MWB);
        end else begin
          q.push_back(P_MW);
        end
      end
      2'b10: q.push_back(P_BR);
      default: ;
    endcase
  endtask

  initial begin
    int q[$];
    int abort_at;
    logic [1:0] rop;
    logic [5:0] rfunct;

    reset = 1'b1;
    Op = 2'b00;
    Funct = 6'b000000;

    // Reset held two cycles: outputs show FETCH values throughout.
    @(posedge clk); @(negedge clk);
    check("reset cyc0", obs, O_FETCH);
    @(posedge clk); @(negedge clk);
    check("reset cyc1", obs, O_FETCH);
    reset = 1'b0;
    $display("reset released");

    // Directed vector table.
    vecs[0] = mk(2'b00, 6'b000000, 3'd4, O_FETCH, O_DECODE, O_EXR,    O_ALUWB, O_ZERO);
    vecs[1] = mk(2'b01, 6'b011001, 3'd5, O_FETCH, O_DECODE, O_MEMADR, O_MEMRD, O_MEMWB);
    vecs[2] = mk(2'b01, 6'b011000, 3'd4, O_FETCH, O_DECODE, O_MEMADR, O_MEMWR, O_ZERO);
    vecs[3] = mk(2'b10, 6'b000000, 3'd3, O_FETCH, O_DECODE, O_BRANCH, O_ZERO,  O_ZERO);
    vecs[4] = mk(2'b00, 6'b100000, 3'd4, O_FETCH, O_DECODE, O_EXI,    O_ALUWB, O_ZERO);
    vecs[5] = mk(2'b11, 6'b000000, 3'd2, O_FETCH, O_DECILL, O_ZERO,   O_ZERO,  O_ZERO);
    vecs[6] = mk(2'b00, 6'b100001, 3'd4, O_FETCH, O_DECODE, O_EXI,    O_ALUWB, O_ZERO);
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    check("after table fetch", obs, O_FETCH);

    // Reset during MEMRD of a load: MEMWB must never appear.
    Op = 2'b01; Funct = 6'b011001;
    check("ldr-abort fetch", obs, O_FETCH);
    @(posedge clk); @(negedge clk);
    check("ldr-abort decode", obs, O_DECODE);
    @(posedge clk); @(negedge clk);
    check("ldr-abort memadr", obs, O_MEMADR);
    @(posedge clk); @(negedge clk);
    check("ldr-abort memrd", obs, O_MEMRD);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("ldr-abort after reset", obs, O_FETCH);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ldr-abort restart decode", obs, O_DECODE);
    @(posedge clk); @(negedge clk);
    check("ldr-abort restart memadr", obs, O_MEMADR);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("ldr-abort restart memwb", obs, O_MEMWB);
    @(posedge clk); @(negedge clk);
    $display("load abort sequence done");

    // Unencoded state value: all outputs low, then FETCH on the next edge.
    check("pre-force fetch", obs, O_FETCH);
    force dut.state_reg = 4'hC;
    #1;
    check("unencoded outputs", obs, O_ZERO);
    release dut.state_reg;
    #1;
    @(posedge clk); @(negedge clk);
    check("unencoded recovers", obs, O_FETCH);
    $display("unencoded state sequence done");

    // Randomized instructions against the phase model, some with reset aborts.
    for (int n = 0; n < 150; n++) begin
      rop = 2'($urandom_range(0, 3));
      rfunct = 6'($urandom);
      model_phases(rop, rfunct, q);
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, q.size() - 1)) : -1;
      Op = rop;
      Funct = rfunct;
      for (int k = 0; k < q.size(); k++) begin
        check($sformatf("rnd%0d cyc%0d", n, k), obs, phase_out(q[k], rop));
        if (k == abort_at) begin
          reset = 1'b1;
          @(posedge clk); @(negedge clk);
          check($sformatf("rnd%0d reset", n), obs, O_FETCH);
          reset = 1'b0;
          break;
        end
        @(posedge clk); @(negedge clk);
      end
      $display("rnd%0d op=%b funct=%b phases=%0d abort=%0d", n, rop, rfunct, q.size(), abort_at);
    end
    check("final fetch", obs, O_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Main control state machine for the multicycle processor variant. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects, the instruction-register load and the PC update. Its unconditional write requests (RegW, MemW, Branch) feed the decode stage, which forms PCS and hands RegW, MemW and PCS to the conditional-logic stage for gating by CondEx.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; forces state to FETCH
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal
- Funct  in  6  instruction bits [25:20]; Funct[5] = immediate (I), Funct[0] = load/set-flags (L/S)
- IRWrite  out  1  load instruction register
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register
- ALUSrcA  out  2  00 = register A, 01 = PC
- ALUSrcB  out  2  00 = register B, 01 = extended immediate, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut register, 01 = data register, 10 = ALU result (direct)
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = add; FlagW is meaningful only when 1
- NextPC  out  1  unconditional PC write (PC+4 at fetch)
- RegW  out  1  register-write request, ungated
- MemW  out  1  memory-write request, ungated
- Branch  out  1  branch request, ungated
- Illegal  out  1  one-cycle pulse: DECODE saw Op = 11

## Operation
- Moore machine. States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Outputs are a pure function of the state register, except Illegal, which is DECODE & (Op == 11).
- Every output not listed for a state is 0.

State outputs:
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0. This computes PC+8 for R15 reads.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
- MEMRD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1.

Transitions:
- FETCH -> DECODE.
- DECODE:
  - Op=01 -> MEMADR
  - Op=00 & Funct[5]=0 -> EXECUTER
  - Op=00 & Funct[5]=1 -> EXECUTEI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH, with Illegal=1 for that cycle; the instruction is a NOP.
- MEMADR: Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
- MEMRD -> MEMWB -> FETCH.
- MEMWR -> FETCH.
- EXECUTER and EXECUTEI -> ALUWB -> FETCH.
- BRANCH -> FETCH.
- Any unencoded state register value -> FETCH next cycle; outputs are all 0 while in it.

Other rules:
- Op and Funct are sampled only in DECODE and MEMADR. They come from the instruction register, which is stable after FETCH.
- Whether a request takes effect (RegW, MemW, Branch/PCS, flag write in EXECUTE*) is decided downstream by CondEx. This block never sees the condition field.

## Timing
- Reset: if reset is high at a rising edge, the state is FETCH after that edge. This takes priority over every transition. Reset mid-instruction abandons it, and no RegW, MemW or Branch is asserted after the reset edge except as FETCH defines (none).
- Outputs during and after reset equal the FETCH values: IRWrite=1, NextPC=1, ALUSrcB=10, ResultSrc=10, ALUSrcA=01, all else 0.
- Instruction latencies in cycles, counting from FETCH:
  - branch 3
  - data-processing 4
  - store 4
  - load 5
  - illegal 2
- Each state lasts exactly one cycle; there are no stall inputs.
- Output changes are glitch-free relative to the clock: they come from the state register through decode only. Illegal alone depends on Op.

## Test plan
- Reset held 2 cycles, then released with Op=00, Funct=000000 → state sequence FETCH, DECODE, EXECUTER, ALUWB, FETCH. RegW=1 only in the ALUWB cycle; ALUOp=1 only in EXECUTER.
- Op=01, Funct=011001 (LDR) → FETCH, DECODE, MEMADR, MEMRD, MEMWB. AdrSrc=1 in MEMRD; ResultSrc=01 and RegW=1 in MEMWB; MemW never set.
- Op=01, Funct=011000 (STR) → MEMWR reached in cycle 4 with MemW=1 and AdrSrc=1, then FETCH; RegW never set.
- Op=10 → BRANCH in cycle 3 with Branch=1, ALUSrcB=01, ResultSrc=10, then FETCH. Op=00 with Funct=100000 → EXECUTEI with ALUSrcB=01.
- Op=11 → Illegal=1 for the DECODE cycle only, next state FETCH, no RegW, MemW or Branch asserted.
- Reset asserted during MEMRD of a load → next state FETCH, MEMWB never entered, RegW stays 0. Also, force an unencoded state value → FETCH on the next edge.
